// File: rtl/rank_select_pkg.sv
// Shared FSM encoding and width helpers for the rank-select actor.
// Feature macro: MEDIAN_RANK_PORT_EN (per-window rank taken from a rank FIFO).
package rank_select_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Bits needed to count 0..win_size inclusive.
    function automatic int cnt_width(input int win_size);
        return $clog2(win_size + 1);
    endfunction

    function automatic int bin_count(input int px_w);
        return 1 << px_w;
    endfunction

endpackage

// File: rtl/rank_hist_bank.sv
// Histogram bank: one counter per pixel value, an increment port and a
// read-and-clear port. The owner guarantees the two ports are never active together.
module rank_hist_bank
    import rank_select_pkg::*;
#(
    parameter int PX_W  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [PX_W-1:0]  inc_addr,
    input  logic             clr_en,
    input  logic [PX_W-1:0]  clr_addr,
    output logic [CNT_W-1:0] rd_data
);

    localparam int NBINS = bin_count(PX_W);

    logic [CNT_W-1:0] bin_val [NBINS];

    generate
        for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (clr_en && (clr_addr == PX_W'(gi))) begin
                    cnt_reg <= '0;
                end else if (inc_en && (inc_addr == PX_W'(gi))) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign bin_val[gi] = cnt_reg;
        end
    endgenerate

    // Combinational read so the scanner can accumulate and clear in one cycle.
    assign rd_data = bin_val[clr_addr];

endmodule

// File: rtl/rank_select_actor.sv
// Histogram-based rank (median) selector over fixed-size pixel windows.
// Feature macro: MEDIAN_RANK_PORT_EN adds an in_rank FIFO port; otherwise RANK is used.
module rank_select_actor
    import rank_select_pkg::*;
#(
    parameter int   PX_W     = 8,
    parameter int   WIN_SIZE = 9,
    parameter int   RANK     = (WIN_SIZE - 1) / 2,
    localparam int  CNT_W    = cnt_width(WIN_SIZE),
    localparam int  NBINS    = bin_count(PX_W)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PX_W-1:0]  in_px,
    output logic             in_px_rd,
    input  logic             in_px_empty,
`ifdef MEDIAN_RANK_PORT_EN
    input  logic [CNT_W-1:0] in_rank,
    output logic             in_rank_rd,
    input  logic             in_rank_empty,
`endif
    output logic [PX_W-1:0]  out_px,
    output logic             out_px_wr,
    input  logic             out_px_full
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] win_cnt_reg;
    logic [CNT_W-1:0] cum_reg;
    logic [CNT_W-1:0] rank_reg;
    logic [PX_W-1:0]  idx_reg;
    logic [PX_W-1:0]  result_reg;
    logic             found_reg;

    logic [CNT_W-1:0] bin_rd_data;
    logic [CNT_W:0]   cum_sum;
    logic             hit;
    logic             rank_take;
    logic             scanning;
    logic [CNT_W-1:0] rank_src;

    // Ranks past the last position select the window maximum.
`ifdef MEDIAN_RANK_PORT_EN
    assign rank_src = (in_rank >= CNT_W'(WIN_SIZE)) ? CNT_W'(WIN_SIZE - 1) : in_rank;
`else
    localparam int RANK_CLAMPED = (RANK >= WIN_SIZE) ? (WIN_SIZE - 1) : RANK;
    assign rank_src = CNT_W'(RANK_CLAMPED);
`endif

    assign scanning = (state_reg == ST_SCAN);
    assign cum_sum  = {1'b0, cum_reg} + {1'b0, bin_rd_data};
    assign hit      = !found_reg && (cum_sum > {1'b0, rank_reg});
    assign out_px   = result_reg;

    rank_hist_bank #(
        .PX_W  (PX_W),
        .CNT_W (CNT_W)
    ) u_bank (
        .clock    (clock),
        .reset    (reset),
        .inc_en   (in_px_rd),
        .inc_addr (in_px),
        .clr_en   (scanning),
        .clr_addr (idx_reg),
        .rd_data  (bin_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_px_rd   = 1'b0;
        out_px_wr  = 1'b0;
        rank_take  = 1'b0;
`ifdef MEDIAN_RANK_PORT_EN
        in_rank_rd = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
`ifdef MEDIAN_RANK_PORT_EN
                if (!in_rank_empty) begin
                    in_rank_rd = 1'b1;
                    rank_take  = 1'b1;
                    state_next = ST_FILL;
                end
`else
                rank_take  = 1'b1;
                state_next = ST_FILL;
`endif
            end
            ST_FILL: begin
                in_px_rd = !in_px_empty;
                if (in_px_rd && (win_cnt_reg == CNT_W'(WIN_SIZE - 1))) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_reg == PX_W'(NBINS - 1)) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                out_px_wr = !out_px_full;
                if (out_px_wr) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Scan visits every bin so the histogram is empty again for the next window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt_reg <= '0;
            cum_reg     <= '0;
            rank_reg    <= '0;
            idx_reg     <= '0;
            result_reg  <= '0;
            found_reg   <= 1'b0;
        end else begin
            if (rank_take) begin
                rank_reg    <= rank_src;
                cum_reg     <= '0;
                win_cnt_reg <= '0;
                idx_reg     <= '0;
                found_reg   <= 1'b0;
            end
            if (in_px_rd) begin
                win_cnt_reg <= win_cnt_reg + CNT_W'(1);
            end
            if (scanning) begin
                cum_reg <= cum_sum[CNT_W-1:0];
                idx_reg <= idx_reg + PX_W'(1);
                if (hit) begin
                    result_reg <= idx_reg;
                    found_reg  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rank_select_actor.sv
// Directed bench for rank_select_actor: FWFT input/output FIFO models around the DUT.
module tb_rank_select_actor;

    localparam int PX_W     = 8;
    localparam int WIN_SIZE = 9;
    localparam int CNT_W    = 4;
    localparam int NBINS    = 256;

    logic             clock;
    logic             reset;
    logic [PX_W-1:0]  in_px;
    logic             in_px_rd;
    logic             in_px_empty;
    logic [PX_W-1:0]  out_px;
    logic             out_px_wr;
    logic             out_px_full;
`ifdef MEDIAN_RANK_PORT_EN
    logic [CNT_W-1:0] in_rank;
    logic             in_rank_rd;
    logic             in_rank_empty;
    int               rank_q [$];
`endif

    rank_select_actor #(
        .PX_W     (PX_W),
        .WIN_SIZE (WIN_SIZE)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_px         (in_px),
        .in_px_rd      (in_px_rd),
        .in_px_empty   (in_px_empty),
`ifdef MEDIAN_RANK_PORT_EN
        .in_rank       (in_rank),
        .in_rank_rd    (in_rank_rd),
        .in_rank_empty (in_rank_empty),
`endif
        .out_px        (out_px),
        .out_px_wr     (out_px_wr),
        .out_px_full   (out_px_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [PX_W-1:0] px_q [$];
    int  cyc = 0;
    int  pop_cnt = 0;
    int  wr_cnt = 0;
    int  rd_viol = 0;
    int  wr_viol = 0;
    int  last_pop_cyc = 0;
    int  last_wr_cyc = 0;
    logic [PX_W-1:0] last_wr_px = '0;
    bit  gap_mode = 0;
    bit  gap_tog = 0;
    bit  full_force = 0;
    int  checks = 0;
    int  passed = 0;

    always @(posedge clock) cyc++;

    // FIFO models: drive inputs on the falling edge, record handshakes just after.
    initial begin
        in_px_empty = 1'b1;
        in_px       = '0;
        out_px_full = 1'b0;
`ifdef MEDIAN_RANK_PORT_EN
        in_rank_empty = 1'b1;
        in_rank       = '0;
`endif
        forever begin
            @(negedge clock);
            gap_tog     = ~gap_tog;
            in_px_empty = (px_q.size() == 0) || (gap_mode && gap_tog);
            if (px_q.size() != 0) in_px = px_q[0];
            out_px_full = full_force;
`ifdef MEDIAN_RANK_PORT_EN
            in_rank_empty = (rank_q.size() == 0);
            if (rank_q.size() != 0) in_rank = CNT_W'(rank_q[0]);
`endif
            #1;
            if (in_px_rd && in_px_empty) rd_viol++;
            if (out_px_wr && out_px_full) wr_viol++;
            if (in_px_rd && !in_px_empty) begin
                void'(px_q.pop_front());
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (out_px_wr) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                last_wr_px  = out_px;
            end
`ifdef MEDIAN_RANK_PORT_EN
            if (in_rank_rd && !in_rank_empty) void'(rank_q.pop_front());
`endif
        end
    end

    task automatic run_window(input string name, input logic [PX_W-1:0] px [WIN_SIZE],
                              input int rnk, input logic [PX_W-1:0] exp_px);
        int p0 = pop_cnt;
        int w0 = wr_cnt;
        int n  = 0;
`ifdef MEDIAN_RANK_PORT_EN
        rank_q.push_back(rnk);
`else
        if (rnk < 0) $display("unused rank %0d", rnk);
`endif
        for (int i = 0; i < WIN_SIZE; i++) px_q.push_back(px[i]);
        while (wr_cnt == w0 && n < 3000) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (wr_cnt == w0) $display("FAIL %s timeout: no out_px_wr after %0d cycles", name, n);
        else if (last_wr_px !== exp_px) $display("FAIL %s result: got %0d expected %0d", name, last_wr_px, exp_px);
        else passed++;
        checks++;
        if (pop_cnt - p0 !== WIN_SIZE) $display("FAIL %s pops: got %0d expected %0d", name, pop_cnt - p0, WIN_SIZE);
        else passed++;
        checks++;
        if (last_wr_cyc - last_pop_cyc !== NBINS + 1)
            $display("FAIL %s latency: got %0d expected %0d", name, last_wr_cyc - last_pop_cyc, NBINS + 1);
        else passed++;
        repeat (5) @(posedge clock);
        checks++;
        if (wr_cnt - w0 !== 1) $display("FAIL %s writes: got %0d expected 1", name, wr_cnt - w0);
        else passed++;
        $display("window %s: out_px=%0d expected=%0d pops=%0d writes=%0d", name, last_wr_px, exp_px, pop_cnt - p0, wr_cnt - w0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock); #2;
        checks++;
        if (out_px !== '0) $display("FAIL reset out_px: got %0d expected 0", out_px); else passed++;
        checks++;
        if (out_px_wr !== 1'b0) $display("FAIL reset out_px_wr: got %0b expected 0", out_px_wr); else passed++;
        checks++;
        if (in_px_rd !== 1'b0) $display("FAIL reset in_px_rd: got %0b expected 0", in_px_rd); else passed++;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock); #2;
        checks++;
        if (in_px_rd !== 1'b0) $display("FAIL idle_empty in_px_rd: got %0b expected 0", in_px_rd); else passed++;
        $display("reset: out_px=%0d out_px_wr=%0b in_px_rd=%0b", out_px, out_px_wr, in_px_rd);
    endtask

    task automatic test_median();
        run_window("median", '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5}, 4, 8'd5);
    endtask

    task automatic test_back_to_back();
        run_window("uniform200", '{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200}, 4, 8'd200);
        run_window("ramp0to8", '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 4, 8'd4);
        run_window("extremes", '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255}, 4, 8'd255);
    endtask

    task automatic test_backpressure();
        logic [PX_W-1:0] px [WIN_SIZE] = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        int p0 = pop_cnt;
        int w0 = wr_cnt;
        int n = 0;
        int bad_px = 0;
        full_force = 1'b1;
`ifdef MEDIAN_RANK_PORT_EN
        rank_q.push_back(4);
`endif
        for (int i = 0; i < WIN_SIZE; i++) px_q.push_back(px[i]);
        while (pop_cnt - p0 < WIN_SIZE && n < 200) begin
            @(posedge clock);
            n++;
        end
        repeat (NBINS + 3) @(posedge clock);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #2;
            if (out_px !== 8'd5) bad_px++;
        end
        checks++;
        if (bad_px != 0) $display("FAIL full_hold out_px: %0d cycles differed from required 5", bad_px);
        else passed++;
        checks++;
        if (wr_cnt != w0) $display("FAIL full_hold out_px_wr: got %0d writes expected 0", wr_cnt - w0);
        else passed++;
        full_force = 1'b0;
        n = 0;
        while (wr_cnt == w0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        repeat (5) @(posedge clock);
        checks++;
        if (wr_cnt - w0 !== 1 || last_wr_px !== 8'd5)
            $display("FAIL full_release: got %0d writes value %0d expected 1 write value 5", wr_cnt - w0, last_wr_px);
        else passed++;
        $display("backpressure: writes=%0d out_px=%0d", wr_cnt - w0, last_wr_px);
    endtask

    task automatic test_reset_mid_window();
        int p0 = pop_cnt;
        int n = 0;
        for (int i = 0; i < WIN_SIZE; i++) px_q.push_back(8'd50);
`ifdef MEDIAN_RANK_PORT_EN
        rank_q.push_back(4);
`endif
        while (pop_cnt - p0 < 4 && n < 100) begin
            @(posedge clock);
            n++;
        end
        @(negedge clock);
        reset = 1'b1;
        px_q.delete();
`ifdef MEDIAN_RANK_PORT_EN
        rank_q.delete();
`endif
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_window("reset_mid", '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18}, 4, 8'd14);
    endtask

    task automatic test_input_gaps();
        gap_mode = 1'b1;
        run_window("gaps", '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5}, 4, 8'd5);
        gap_mode = 1'b0;
    endtask

`ifdef MEDIAN_RANK_PORT_EN
    task automatic test_rank_port();
        run_window("rank0", '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5}, 0, 8'd1);
        run_window("rank_clamp", '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5}, 15, 8'd9);
    endtask
`endif

    task automatic test_handshake_rules();
        checks++;
        if (rd_viol != 0) $display("FAIL in_px_rd_while_empty: got %0d expected 0", rd_viol); else passed++;
        checks++;
        if (wr_viol != 0) $display("FAIL out_px_wr_while_full: got %0d expected 0", wr_viol); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_median();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_window();
        test_input_gaps();
`ifdef MEDIAN_RANK_PORT_EN
        test_rank_port();
`endif
        test_handshake_rules();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
